// File: rtl/seg7_scan_decoder.sv
// Seven-segment bus capture: debounces each strobed digit pattern,
// decodes it back to BCD and reports per-digit and frame status.
module seg7_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int STABLE = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a,
  input  logic                  b,
  input  logic                  c,
  input  logic                  d,
  input  logic                  e,
  input  logic                  f,
  input  logic                  g,
  input  logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid,
  output logic                  strobe_err
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int IW = DIGITS + 7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_HELD  = 2'd2;

  logic [IW-1:0]       in_d;
  logic [IW-1:0]       in_q;
  logic [CW-1:0]       cnt_d;
  logic [CW-1:0]       cnt_q;
  logic [1:0]          state_d;
  logic [1:0]          state_q;
  logic                chg_q;
  logic [DIGITS-1:0]   seen_d;
  logic [DIGITS-1:0]   seen_q;
  logic [4*DIGITS-1:0] bcd_d;
  logic [4*DIGITS-1:0] bcd_q;
  logic [DIGITS-1:0]   err_d;
  logic [DIGITS-1:0]   err_q;
  logic                fv_d;
  logic                fv_q;
  logic                se_d;
  logic                se_q;

  logic                match;
  logic                cnt_full;
  logic                capture;
  logic [DIGITS-1:0]   dig_q;
  logic [DIGITS-1:0]   seen_set;
  logic [4:0]          dec;
  logic                dec_ok;
  logic [3:0]          dec_val;

  // {valid, digit}; anything outside the table is invalid
  function automatic logic [4:0] seg_decode(
    input logic [6:0] s
  );
    logic [4:0] r;
    r = 5'd0;
    case (s)
      7'h3f:   r = {1'b1, 4'd0};
      7'h06:   r = {1'b1, 4'd1};
      7'h5b:   r = {1'b1, 4'd2};
      7'h4f:   r = {1'b1, 4'd3};
      7'h66:   r = {1'b1, 4'd4};
      7'h6d:   r = {1'b1, 4'd5};
      7'h7d:   r = {1'b1, 4'd6};
      7'h07:   r = {1'b1, 4'd7};
      7'h7f:   r = {1'b1, 4'd8};
      7'h6f:   r = {1'b1, 4'd9};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  assign in_d     = {dig_en, g, f, e, d, c, b, a};
  assign match    = (in_d == in_q);
  assign dig_q    = in_q[IW-1:7];
  assign cnt_full = (cnt_q == CW'(STABLE));

  assign dec     = seg_decode(in_q[6:0]);
  assign dec_ok  = dec[4];
  assign dec_val = dec[3:0];

  assign capture = match
                 && (state_q == S_TRACK)
                 && cnt_full;

  always_comb begin
    cnt_d = cnt_q;
    if (!match) begin
      cnt_d = CW'(1);
    end else if (!cnt_full) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (!match) begin
      state_d = $onehot(dig_en) ? S_TRACK : S_IDLE;
    end else begin
      case (state_q)
        S_TRACK: begin
          if (cnt_full) begin
            state_d = S_HELD;
          end
        end
        S_HELD:  state_d = S_HELD;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bcd_d    = bcd_q;
    err_d    = err_q;
    seen_set = seen_q;
    seen_d   = seen_q;
    fv_d     = 1'b0;
    if (capture) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (dig_q[i]) begin
          if (dec_ok) begin
            bcd_d[4*i +: 4] = dec_val;
            err_d[i]        = 1'b0;
          end else begin
            err_d[i]        = 1'b1;
          end
        end
      end
      seen_set = seen_q | dig_q;
      if (&seen_set) begin
        fv_d   = 1'b1;
        seen_d = '0;
      end else begin
        seen_d = seen_set;
      end
    end
  end

  // chg_q marks that in_q was just reloaded, so one pulse per new value
  assign se_d = chg_q && !$onehot0(dig_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q    <= '0;
      cnt_q   <= '0;
      state_q <= S_IDLE;
      chg_q   <= 1'b0;
      seen_q  <= '0;
      bcd_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      in_q    <= in_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      chg_q   <= !match;
      seen_q  <= seen_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
    end
  end

  assign bcd         = bcd_q;
  assign digit_err   = err_q;
  assign frame_valid = fv_q;
  assign strobe_err  = se_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: run-length reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_seg7_scan_decoder;

  localparam int DIGITS = 4;
  localparam int STABLE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  segs = 7'h00;
  logic [3:0]  dig_en = 4'h0;
  logic        a, b, c, d, e, f, g;
  logic [15:0] bcd;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        strobe_err;

  assign {g, f, e, d, c, b, a} = segs;

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .DIGITS(DIGITS),
    .STABLE(STABLE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a(a), .b(b), .c(c), .d(d),
    .e(e), .f(f), .g(g),
    .dig_en(dig_en),
    .bcd(bcd),
    .digit_err(digit_err),
    .frame_valid(frame_valid),
    .strobe_err(strobe_err)
  );

  logic [6:0] pat [10] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66,
    7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f
  };

  int checks = 0;
  int errors = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // reference model: capture when a value has been seen on
  // exactly STABLE+1 consecutive edges
  logic [10:0] m_prev = '0;
  int          m_run = 0;
  logic [3:0]  m_nib [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0]  m_err = '0;
  logic [3:0]  m_seen = '0;
  logic        m_fv = 1'b0;
  logic        m_se = 1'b0;
  logic        m_pend = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_prev = '0;
      m_run  = 0;
      for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
      m_err  = '0;
      m_seen = '0;
      m_fv   = 1'b0;
      m_se   = 1'b0;
      m_pend = 1'b0;
    end else begin
      logic [10:0] key;
      int pos;
      int dv;
      key = {dig_en, segs};
      if (key !== m_prev) m_run = 1;
      else if (m_run < 1000) m_run++;
      m_fv   = 1'b0;
      m_se   = m_pend;
      m_pend = (m_run == 1) && ($countones(dig_en) > 1);
      if (m_run == STABLE + 1 && $countones(dig_en) == 1) begin
        pos = 0;
        for (int i = 0; i < 4; i++) if (dig_en[i]) pos = i;
        dv = -1;
        for (int k = 0; k < 10; k++) if (pat[k] == segs) dv = k;
        if (dv >= 0) begin
          m_nib[pos] = 4'(dv);
          m_err[pos] = 1'b0;
        end else begin
          m_err[pos] = 1'b1;
        end
        m_seen[pos] = 1'b1;
        if (m_seen == 4'hf) begin
          m_fv   = 1'b1;
          m_seen = '0;
        end
      end
      m_prev = key;
    end
  end

  int fv_cnt = 0;
  int se_cnt = 0;
  logic watch2 = 1'b0;
  logic saw2 = 1'b0;

  initial forever begin
    @(negedge clk);
    chk("bcd", 32'(bcd),
        32'({m_nib[3], m_nib[2], m_nib[1], m_nib[0]}));
    chk("digit_err", 32'(digit_err), 32'(m_err));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("strobe_err", 32'(strobe_err), 32'(m_se));
    if (frame_valid === 1'b1) fv_cnt++;
    if (strobe_err === 1'b1) se_cnt++;
    if (watch2 && bcd[7:4] == 4'd2) saw2 = 1'b1;
  end

  task automatic drive(
    input logic [3:0] en,
    input logic [6:0] sg,
    input int         n
  );
    @(negedge clk);
    dig_en = en;
    segs   = sg;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic blank();
    drive(4'h0, 7'h00, 2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    dig_en = 4'h0;
    segs = 7'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int base;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_err", 32'(digit_err), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_se", 32'(strobe_err), 32'h0);
    rst_n = 1'b1;

    // 1,2,3,4 across positions 0..3
    base = fv_cnt;
    drive(4'b0001, pat[1], 5);
    drive(4'b0010, pat[2], 5);
    drive(4'b0100, pat[3], 5);
    drive(4'b1000, pat[4], 5);
    blank();
    chk("t1_bcd", 32'(bcd), 32'h4321);
    chk("t1_fv", 32'(fv_cnt - base), 32'd1);
    chk("t1_err", 32'(digit_err), 32'h0);

    // short glitch of 2 must never land
    do_reset();
    watch2 = 1'b1;
    drive(4'b0010, pat[2], 2);
    drive(4'b0010, pat[7], 5);
    blank();
    watch2 = 1'b0;
    chk("t2_nib1", 32'(bcd[7:4]), 32'd7);
    chk("t2_no2", 32'(saw2), 32'd0);

    // invalid pattern keeps the old nibble
    drive(4'b0100, pat[5], 5);
    drive(4'b0100, 7'h01, 6);
    blank();
    chk("t3_err2", 32'(digit_err[2]), 32'd1);
    chk("t3_nib2", 32'(bcd[11:8]), 32'd5);
    drive(4'b0100, pat[8], 5);
    blank();
    chk("t3_nib2b", 32'(bcd[11:8]), 32'd8);
    chk("t3_err2b", 32'(digit_err[2]), 32'd0);

    // multi-hot strobe
    base = se_cnt;
    drive(4'b0110, pat[3], 6);
    blank();
    chk("t4_se", 32'(se_cnt - base), 32'd1);
    chk("t4_bcd", 32'(bcd), 32'h0870);
    base = fv_cnt;
    drive(4'b0001, pat[0], 5);
    drive(4'b1000, pat[9], 5);
    blank();
    chk("t4_fv", 32'(fv_cnt - base), 32'd1);
    chk("t4_bcd2", 32'(bcd), 32'h9870);

    // asynchronous reset mid-frame
    drive(4'b0001, pat[6], 5);
    drive(4'b0010, pat[5], 5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_bcd", 32'(bcd), 32'h0);
    chk("t5_err", 32'(digit_err), 32'h0);
    chk("t5_fv", 32'(frame_valid), 32'h0);
    chk("t5_se", 32'(strobe_err), 32'h0);
    dig_en = 4'h0;
    segs = 7'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = fv_cnt;
    drive(4'b0100, pat[1], 5);
    drive(4'b1000, pat[2], 5);
    blank();
    chk("t5_nofv", 32'(fv_cnt - base), 32'd0);
    drive(4'b0001, pat[3], 5);
    drive(4'b0010, pat[4], 5);
    blank();
    chk("t5_fv1", 32'(fv_cnt - base), 32'd1);
    chk("t5_bcd2", 32'(bcd), 32'h2143);

    // recapture of position 0 does not advance the frame
    base = fv_cnt;
    drive(4'b0001, pat[3], 5);
    drive(4'b0001, pat[9], 5);
    drive(4'b0010, pat[1], 5);
    drive(4'b0100, pat[1], 5);
    blank();
    chk("t6_nofv", 32'(fv_cnt - base), 32'd0);
    chk("t6_nib0", 32'(bcd[3:0]), 32'd9);
    drive(4'b1000, pat[7], 5);
    blank();
    chk("t6_fv", 32'(fv_cnt - base), 32'd1);
    chk("t6_bcd", 32'(bcd), 32'h7119);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side decoder for a multiplexed, active-high seven-segment display bus. It samples the segment lines a..g together with a one-hot digit strobe and waits until each strobed pattern has been stable for STABLE cycles. It then converts the pattern back to a BCD digit and stores it in a per-digit register, pulsing frame_valid once every digit position has been captured. It sits on the display side of the segment interface: display-capture test fixtures and loopback self-check use it to read back what the BCD-to-segment drivers emit.

## Interface
- DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE, 3, consecutive identical samples required before capture (2..15).
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a, b, c, d, e, f, g  input  1 each  segment lines, active-high (a top, b upper-right, c lower-right, d bottom, e lower-left, f upper-left, g middle).
- dig_en  input  DIGITS  digit strobe, expected one-hot; bit i selects position i.
- bcd  output  4*DIGITS  captured digits; nibble i = bcd[4i+3:4i].
- digit_err  output  DIGITS  bit i set when the last capture at position i was a non-decimal pattern.
- frame_valid  output  1  one-cycle pulse when all positions have been captured since the previous pulse.
- strobe_err  output  1  one-cycle pulse when dig_en is sampled with more than one bit set.

## Operation
- Input register holds {dig_en, g..a}. Each edge compares the live inputs with the register. On a mismatch, cnt is loaded with 1. On a match, cnt increments and saturates at STABLE.
- FSM states:
  - IDLE: registered dig_en is zero or not one-hot.
  - TRACK: valid strobe, not yet captured.
  - HELD: captured, waiting for the inputs to change.
- FSM transitions:
  - Any input change, or an invalid strobe, returns the FSM to IDLE or TRACK.
  - TRACK goes to HELD on the edge where cnt==STABLE.
  - HELD never recaptures.
- Decode table (segments lit; all others dark):
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg
  - 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg
- Capture at position i:
  - Table match: nibble i is loaded and digit_err[i] is cleared.
  - Any other pattern (including all-dark): nibble i is retained and digit_err[i] is set.
  - In both cases seen[i] is set.
- Frame completion:
  - When a capture makes seen all-ones, frame_valid pulses and seen clears on the same edge.
  - Recapturing a position already in seen overwrites it and does not advance the frame.
- strobe_err pulses on the first edge at which the input register takes a multi-hot dig_en value. No capture happens while dig_en is multi-hot.
- dig_en all-zero is legal blanking: no capture, no error.

## Timing
- Reset values:
  - Outputs: bcd=0, digit_err=0, frame_valid=0, strobe_err=0.
  - Internal: seen=0, cnt=0, FSM=IDLE, input register=0.
- Reset is asynchronous. Asserting rst_n mid-frame discards all partial captures immediately.
- Latency: if edge N is the first edge that samples a new stable value, bcd, digit_err and frame_valid update at edge N+STABLE.
- A change at any edge before N+STABLE restarts the count. Glitches shorter than STABLE cycles therefore never capture.
- A multi-hot value sampled at edge N produces a strobe_err pulse at edge N+1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Digits 1,2,3,4 strobed at positions 0..3, each held 5 cycles (STABLE=3). Required: bcd=16'h4321 after the 4th capture, exactly one frame_valid pulse, digit_err=0.
- Position 1 held with pattern 2 for only 2 cycles, then 5 cycles with pattern 7. Required: nibble 1 becomes 7 only, with no intermediate value 2.
- Position 2 held with segments a-only (invalid) for 6 cycles after a prior value of 5. Required: digit_err[2]=1 and nibble 2 stays 5. A later valid 8 gives nibble 2 = 8 and digit_err[2]=0.
- dig_en=4'b0110 held for 6 cycles. Required: a single strobe_err pulse, no bcd change, seen unchanged.
- Positions 0 and 1 captured, then rst_n pulsed low mid-cycle. Required: all outputs 0 immediately, and a full 4-digit frame is needed before the next frame_valid.
- Position 0 captured twice (3, then 9) before positions 1..3. Required: nibble 0=9 and one frame_valid only after position 3 is captured.
